// File: rtl/cnt_rec_buffer.sv
// Stopwatch counter with a circular record buffer and oldest-first replay.
// Define CNT_REC_BCD_EN to count in packed BCD (CNT_W must be a multiple of 4).
module cnt_rec_buffer #(
  parameter  int CNT_W = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_p,
  input  logic             rev,
  input  logic             tick_en,
  input  logic             clr,
  output logic [CNT_W-1:0] dis,
  output logic             r_s,
  output logic             running,
  output logic             full,
  output logic [AW:0]      rec_cnt,
  output logic [AW-1:0]    play_idx
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PLAY
  } st_t;

  st_t st, st_nx;

  logic [2:0] sp_sr, rv_sr;
  logic       sp_p, rv_p;
  logic       do_clr, do_sp, do_rv;

  logic [CNT_W-1:0] cnt, cnt_nx, dis_nx;
  logic [AW-1:0]    wr_ptr, wr_nx;
  logic [AW-1:0]    rd_ptr, rd_nx;
  logic [AW-1:0]    pidx_nx;
  logic [AW-1:0]    oldest, idx, ptr;
  logic [AW:0]      rec_nx;
  logic             full_nx;
  logic             arm, arm_nx;
  logic             we;
  logic             last, idx_last;

  logic [CNT_W-1:0] mem [DEPTH];

  function automatic logic [CNT_W-1:0] cnt_inc(
    input logic [CNT_W-1:0] v
  );
`ifdef CNT_REC_BCD_EN
    logic [CNT_W-1:0] r;
    logic             c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < CNT_W / 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
`else
    return v + CNT_W'(1);
`endif
  endfunction

  // 2-FF synchronisers plus one stage for rising-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_sr <= '0;
      rv_sr <= '0;
    end else begin
      sp_sr <= {sp_sr[1:0], s_p};
      rv_sr <= {rv_sr[1:0], rev};
    end
  end

  assign sp_p = sp_sr[1] & ~sp_sr[2];
  assign rv_p = rv_sr[1] & ~rv_sr[2];

  assign do_clr = clr;
  assign do_sp  = sp_p & ~clr;
  assign do_rv  = rv_p & ~sp_p & ~clr;

  assign running = (st == ST_RUN);
  assign r_s     = (st == ST_PLAY);

  assign oldest = full ? wr_ptr : '0;
  assign last   = (({1'b0, play_idx} + (AW+1)'(1)) == rec_cnt);

  always_comb begin
    idx      = '0;
    ptr      = oldest;
    idx_last = 1'b0;
    if (!arm) begin
      idx = last ? '0 : play_idx + AW'(1);
      ptr = rd_ptr;
    end
    idx_last = (({1'b0, idx} + (AW+1)'(1)) == rec_cnt);
  end

  always_comb begin
    st_nx   = st;
    cnt_nx  = cnt;
    dis_nx  = (st == ST_PLAY) ? dis : cnt;
    wr_nx   = wr_ptr;
    rd_nx   = rd_ptr;
    rec_nx  = rec_cnt;
    full_nx = full;
    pidx_nx = play_idx;
    arm_nx  = arm;
    we      = 1'b0;

    if (st == ST_RUN && tick_en) begin
      cnt_nx = cnt_inc(cnt);
    end

    unique case (1'b1)
      do_clr: begin
        st_nx   = ST_IDLE;
        cnt_nx  = '0;
        dis_nx  = '0;
        wr_nx   = '0;
        rd_nx   = '0;
        rec_nx  = '0;
        full_nx = 1'b0;
        pidx_nx = '0;
        arm_nx  = 1'b1;
      end
      do_sp: begin
        dis_nx = cnt;
        if (st == ST_RUN) begin
          st_nx   = ST_IDLE;
          cnt_nx  = cnt;
          we      = 1'b1;
          wr_nx   = wr_ptr + AW'(1);
          rec_nx  = full ? (AW+1)'(DEPTH) : rec_cnt + (AW+1)'(1);
          full_nx = full | (rec_cnt == (AW+1)'(DEPTH - 1));
          arm_nx  = 1'b1;
        end else begin
          st_nx = ST_RUN;
        end
      end
      do_rv: begin
        if (st != ST_RUN) begin
          st_nx = ST_PLAY;
          if (rec_cnt == '0) begin
            dis_nx  = '0;
            pidx_nx = '0;
          end else begin
            dis_nx  = mem[ptr];
            pidx_nx = idx;
            rd_nx   = idx_last ? oldest : ptr + AW'(1);
            arm_nx  = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= ST_IDLE;
      cnt      <= '0;
      dis      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rec_cnt  <= '0;
      full     <= 1'b0;
      play_idx <= '0;
      arm      <= 1'b1;
    end else begin
      st       <= st_nx;
      cnt      <= cnt_nx;
      dis      <= dis_nx;
      wr_ptr   <= wr_nx;
      rd_ptr   <= rd_nx;
      rec_cnt  <= rec_nx;
      full     <= full_nx;
      play_idx <= pidx_nx;
      arm      <= arm_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_ptr] <= cnt;
    end
  end

endmodule

// File: tb/tb_cnt_rec_buffer.sv
// Randomised bench for cnt_rec_buffer against a queue-based reference model.
// Honours CNT_REC_BCD_EN in the model's increment rule.
module tb_cnt_rec_buffer;

  localparam int CNT_W = 8;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst, s_p, rev, tick_en, clr;
  logic [CNT_W-1:0] dis;
  logic             r_s, running, full;
  logic [AW:0]      rec_cnt;
  logic [AW-1:0]    play_idx;

  int n_chk = 0;
  int n_err = 0;

  cnt_rec_buffer #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_p      (s_p),
    .rev      (rev),
    .tick_en  (tick_en),
    .clr      (clr),
    .dis      (dis),
    .r_s      (r_s),
    .running  (running),
    .full     (full),
    .rec_cnt  (rec_cnt),
    .play_idx (play_idx)
  );

  always #5 clk = ~clk;

  int m_cnt, m_dis, m_pidx;
  bit m_run, m_rs, m_arm;
  int recs[$];
  int sp_cd, rv_cd;
  bit sp_q, rv_q;

  function automatic int inc(input int v);
`ifdef CNT_REC_BCD_EN
    int d, mul, r;
    d = 0;
    mul = 1;
    for (int i = 0; i < CNT_W / 4; i++) begin
      d += ((v >> (4 * i)) & 15) * mul;
      mul *= 10;
    end
    d = (d + 1) % mul;
    r = 0;
    for (int i = 0; i < CNT_W / 4; i++) begin
      r |= (d % 10) << (4 * i);
      d /= 10;
    end
    return r;
`else
    return (v + 1) % (1 << CNT_W);
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_dis = 0; m_pidx = 0;
      m_run = 0; m_rs = 0; m_arm = 1;
      recs.delete();
      sp_cd = 0; rv_cd = 0; sp_q = 0; rv_q = 0;
    end else begin : step_model
      bit fs, fr;
      fs = (sp_cd == 1);
      fr = (rv_cd == 1);
      if (sp_cd > 0) sp_cd--;
      if (rv_cd > 0) rv_cd--;
      if (s_p && !sp_q) sp_cd = 2;
      if (rev && !rv_q) rv_cd = 2;
      sp_q = s_p;
      rv_q = rev;
      if (clr) begin
        m_cnt = 0; m_dis = 0; m_pidx = 0;
        m_run = 0; m_rs = 0; m_arm = 1;
        recs.delete();
      end else if (fs) begin
        if (m_run) begin
          recs.push_back(m_cnt);
          if (recs.size() > DEPTH) void'(recs.pop_front());
          m_arm = 1;
        end
        m_run = !m_run;
        m_rs  = 0;
        m_dis = m_cnt;
      end else begin
        if (!m_rs) m_dis = m_cnt;
        if (fr && !m_run) begin
          m_rs = 1;
          if (recs.size() == 0) begin
            m_dis  = 0;
            m_pidx = 0;
          end else begin
            m_pidx = m_arm ? 0 : (m_pidx + 1) % recs.size();
            m_dis  = recs[m_pidx];
            m_arm  = 0;
          end
        end
        if (m_run && tick_en) m_cnt = inc(m_cnt);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("dis", dis, m_dis);
    chk("r_s", r_s, m_rs);
    chk("running", running, m_run);
    chk("full", full, recs.size() == DEPTH);
    chk("rec_cnt", rec_cnt, recs.size());
    chk("play_idx", play_idx, m_pidx);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic press(input bit a, input bit b);
    if (a) s_p = 1'b1;
    if (b) rev = 1'b1;
    step(2);
    s_p = 1'b0;
    rev = 1'b0;
    step(3);
  endtask

  initial begin
    rst = 1'b1; s_p = 1'b0; rev = 1'b0; tick_en = 1'b1; clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dis", dis, 0);
    chk("rst_run", running, 0);
    chk("rst_rec", rec_cnt, 0);
    rst = 1'b0;
    step(2);

    press(0, 1);
    chk("empty_rs", r_s, 1);
    chk("empty_dis", dis, 0);

    press(1, 0);
    step(5);
    press(1, 0);
    for (int k = 1; k <= 3; k++) begin
      press(1, 0);
      step(k * 10);
      press(1, 0);
    end
    repeat (4) press(0, 1);

    press(1, 0);
    press(0, 1);
    step(3);
    press(1, 0);

    for (int k = 0; k < 10; k++) begin
      press(1, 0);
      step($urandom_range(0, 15));
      press(1, 0);
    end
    repeat (9) press(0, 1);
    chk("full_set", full, 1);

    press(1, 1);
    step(4);
    press(1, 1);

    press(1, 0);
    tick_en = 1'b0;
    step(10);
    tick_en = 1'b1;
    step(300);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_full", full, 0);
    step(3);

    press(1, 0);
    step(20);
    rst = 1'b1;
    #1;
    chk("arst_dis", dis, 0);
    chk("arst_run", running, 0);
    step(1);
    rst = 1'b0;
    step(2);

    repeat (300) begin
      tick_en = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: press(1, 0);
        4, 5, 6:    press(0, 1);
        7:          press(1, 1);
        8: begin
          clr = 1'b1;
          step(1);
          clr = 1'b0;
        end
        default:    step($urandom_range(0, 20));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
